// File: rtl/ex_muldiv_pkg.sv
// Shared constants for the EX-stage multiply/divide unit: op codes, FSM encodings
// and the default datapath width.
package ex_muldiv_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_FIX  = 2'b10;

    // Even op codes are the signed variants, the high bit selects divide.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/ex_muldiv_md_step.sv
// One iteration of the shared datapath: multiply add-and-shift on the multiplier LSB,
// or restoring divide (shift remainder:quotient left, trial subtract WIDTH+1 bits).
import ex_muldiv_pkg::*;

module md_step #(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    logic [WIDTH:0] mul_sum_s;
    logic [WIDTH:0] div_shift_s;
    logic [WIDTH:0] div_trial_s;

    // Single mul or div step, selected by the latched op class.
    always_comb begin
        mul_sum_s   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        div_shift_s = {acc_hi, acc_lo[WIDTH-1]};
        div_trial_s = div_shift_s - {1'b0, operand};
        nxt_hi      = acc_hi;
        nxt_lo      = acc_lo;
        if (is_div) begin
            // Non-negative trial result means the divisor fits: keep it, quotient bit 1.
            if (!div_trial_s[WIDTH]) begin
                nxt_hi = div_trial_s[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = div_shift_s[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            nxt_hi = mul_sum_s[WIDTH:1];
            nxt_lo = {mul_sum_s[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; signed ops run on magnitudes
// and are sign-corrected in a final FIX cycle before HI/LO are written.
import ex_muldiv_pkg::*;

module ex_muldiv #(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_busA,
    input  logic [WIDTH-1:0] i_busB,
    input  logic             i_hiWr,
    input  logic             i_loWr,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_busy,
    output logic             o_done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       state_r, state_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] acc_hi_r, acc_lo_r, operand_r, hi_r, lo_r;
    logic             is_div_r, neg_lo_r, neg_hi_r, busy_r, done_r;

    logic             a_neg_s, b_neg_s, div0_s;
    logic [WIDTH-1:0] a_mag_s, b_mag_s, step_hi_s, step_lo_s, fix_hi_s, fix_lo_s;
    logic [2*WIDTH-1:0] prod_s, prod_neg_s;

    md_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div_r),
        .acc_hi  (acc_hi_r),
        .acc_lo  (acc_lo_r),
        .operand (operand_r),
        .nxt_hi  (step_hi_s),
        .nxt_lo  (step_lo_s)
    );

    // Operand magnitudes, divide-by-zero detect and the final sign correction.
    always_comb begin
        a_neg_s    = op_is_signed(i_op) & i_busA[WIDTH-1];
        b_neg_s    = op_is_signed(i_op) & i_busB[WIDTH-1];
        a_mag_s    = a_neg_s ? (~i_busA + ONE_W) : i_busA;
        b_mag_s    = b_neg_s ? (~i_busB + ONE_W) : i_busB;
        div0_s     = op_is_div(i_op) & (i_busB == {WIDTH{1'b0}});
        prod_s     = {acc_hi_r, acc_lo_r};
        prod_neg_s = ~prod_s + ONE_2W;
        if (is_div_r) begin
            fix_hi_s = neg_hi_r ? (~acc_hi_r + ONE_W) : acc_hi_r;
            fix_lo_s = neg_lo_r ? (~acc_lo_r + ONE_W) : acc_lo_r;
        end else begin
            // Product sign applies to the full double-width value.
            fix_hi_s = neg_lo_r ? prod_neg_s[2*WIDTH-1:WIDTH] : acc_hi_r;
            fix_lo_s = neg_lo_r ? prod_neg_s[WIDTH-1:0]       : acc_lo_r;
        end
    end

    // Next-state logic for IDLE -> RUN -> FIX -> IDLE (divide by zero skips RUN).
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt_s = div0_s ? ST_FIX : ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == CW'(1)) begin
                    state_nxt_s = ST_FIX;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FIX:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, iteration datapath and HI/LO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CW{1'b0}};
            acc_hi_r  <= {WIDTH{1'b0}};
            acc_lo_r  <= {WIDTH{1'b0}};
            operand_r <= {WIDTH{1'b0}};
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            is_div_r  <= 1'b0;
            neg_lo_r  <= 1'b0;
            neg_hi_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= (state_nxt_s == ST_FIX);
            case (state_r)
                ST_IDLE: begin
                    if (i_hiWr) hi_r <= i_busA;
                    if (i_loWr) lo_r <= i_busA;
                    if (i_start) begin
                        is_div_r <= op_is_div(i_op);
                        cnt_r    <= CW'(WIDTH);
                        if (div0_s) begin
                            // Preload the architectural divide-by-zero result; FIX passes it through.
                            acc_hi_r  <= i_busA;
                            acc_lo_r  <= {WIDTH{1'b1}};
                            operand_r <= {WIDTH{1'b0}};
                            neg_lo_r  <= 1'b0;
                            neg_hi_r  <= 1'b0;
                        end else if (op_is_div(i_op)) begin
                            acc_hi_r  <= {WIDTH{1'b0}};
                            acc_lo_r  <= a_mag_s;
                            operand_r <= b_mag_s;
                            neg_lo_r  <= a_neg_s ^ b_neg_s;
                            neg_hi_r  <= a_neg_s;
                        end else begin
                            acc_hi_r  <= {WIDTH{1'b0}};
                            acc_lo_r  <= b_mag_s;
                            operand_r <= a_mag_s;
                            neg_lo_r  <= a_neg_s ^ b_neg_s;
                            neg_hi_r  <= a_neg_s ^ b_neg_s;
                        end
                    end
                end
                ST_RUN: begin
                    acc_hi_r <= step_hi_s;
                    acc_lo_r <= step_lo_s;
                    cnt_r    <= cnt_r - CW'(1);
                end
                ST_FIX: begin
                    hi_r <= fix_hi_s;
                    lo_r <= fix_lo_s;
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign o_hi   = hi_r;
    assign o_lo   = lo_r;
    assign o_busy = busy_r;
    assign o_done = done_r;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: expected HI/LO are queued at issue and checked by a
// monitor on the cycle after each done pulse; latency and side-band behaviour checked inline.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start, i_hiWr, i_loWr;
    logic [1:0]  i_op;
    logic [31:0] i_busA, i_busB;
    logic [31:0] o_hi, o_lo;
    logic        o_busy, o_done;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    logic chk_pend = 1'b0;
    logic [63:0] exp_q[$];
    string       name_q[$];

    ex_muldiv dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_op(i_op),
        .i_busA(i_busA), .i_busB(i_busB), .i_hiWr(i_hiWr), .i_loWr(i_loWr),
        .o_hi(o_hi), .o_lo(o_lo), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: the negedge after a done pulse is the first point HI/LO hold the result.
    always @(negedge clk) begin
        if (rst) begin
            chk_pend = 1'b0;
        end else begin
            if (chk_pend) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got result %h_%h expected none", o_hi, o_lo);
                end else begin
                    logic [63:0] e;
                    string nm;
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    chk({nm, "_hi"}, o_hi, e[63:32]);
                    chk({nm, "_lo"}, o_lo, e[31:0]);
                end
            end
            chk_pend = o_done;
            if (o_done) done_cnt++;
        end
    end

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        i_start = 1'b1; i_op = op; i_busA = a; i_busB = b;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic finish_op(input string nm, input int k0, input int lat, input int d0);
        int k;
        k = k0;
        while (o_busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_latency"}, 32'(k), 32'(lat));
        chk({nm, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int lat);
        int d0;
        d0 = done_cnt;
        exp_q.push_back({ehi, elo});
        name_q.push_back(nm);
        start_op(op, a, b);
        finish_op(nm, 1, lat, d0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        int k;
        rst = 1'b1; i_start = 1'b0; i_hiWr = 1'b0; i_loWr = 1'b0;
        i_op = 2'b00; i_busA = 32'h0; i_busB = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_hi", o_hi, 32'h0);
        chk("reset_lo", o_lo, 32'h0);
        chk("reset_busy", {31'h0, o_busy}, 32'h0);
        chk("reset_done", {31'h0, o_done}, 32'h0);
        rst = 1'b0;

        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34);
        run_op("mult_neg",  2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 34);
        run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 34);

        // Second start plus MTHI mid-operation must both be ignored.
        d0 = done_cnt;
        exp_q.push_back({32'h0, 32'h0000000C});
        name_q.push_back("multu_busy_start");
        start_op(2'b01, 32'd3, 32'd4);
        k = 1;
        while (k < 10) begin @(negedge clk); k++; end
        i_start = 1'b1; i_hiWr = 1'b1; i_op = 2'b01; i_busA = 32'd2; i_busB = 32'd2;
        @(negedge clk);
        k++;
        i_start = 1'b0; i_hiWr = 1'b0;
        chk("hi_during_busy", o_hi, 32'h00000002);
        finish_op("multu_busy_start", k, 34, d0);

        run_op("div_neg_dividend", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34);
        run_op("div_overflow", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34);
        run_op("div_neg_divisor", 2'b10, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34);
        run_op("mult_minmin", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 34);
        run_op("divu_by0", 2'b11, 32'h00001234, 32'h0, 32'h00001234, 32'hFFFFFFFF, 2);
        run_op("div_by0", 2'b10, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF, 2);

        @(negedge clk);
        i_loWr = 1'b1; i_busA = 32'h0000ABCD;
        @(negedge clk);
        i_loWr = 1'b0;
        chk("mtlo_lo", o_lo, 32'h0000ABCD);
        chk("mtlo_hi_kept", o_hi, 32'hFFFFFFFB);
        i_hiWr = 1'b1; i_busA = 32'h00005555;
        @(negedge clk);
        i_hiWr = 1'b0;
        chk("mthi_hi", o_hi, 32'h00005555);

        // Start and MTLO together: the write lands first, the result overwrites later.
        d0 = done_cnt;
        exp_q.push_back({32'h00000001, 32'h00000004});
        name_q.push_back("divu_with_mtlo");
        @(negedge clk);
        i_start = 1'b1; i_loWr = 1'b1; i_op = 2'b11; i_busA = 32'd9; i_busB = 32'd2;
        @(negedge clk);
        i_start = 1'b0; i_loWr = 1'b0;
        chk("mtlo_with_start", o_lo, 32'd9);
        finish_op("divu_with_mtlo", 1, 34, d0);

        // Reset mid-divide aborts without a done pulse.
        d0 = done_cnt;
        start_op(2'b10, 32'd1000, 32'd3);
        k = 1;
        while (k < 15) begin @(negedge clk); k++; end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'h0, o_busy}, 32'h0);
        chk("abort_done", {31'h0, o_done}, 32'h0);
        chk("abort_hi", o_hi, 32'h0);
        chk("abort_lo", o_lo, 32'h0);
        rst = 1'b0;
        chk("abort_no_pulse", 32'(done_cnt - d0), 32'd0);

        run_op("multu_after_abort", 2'b01, 32'd6, 32'd7, 32'h0, 32'h0000002A, 34);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
